// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the configurable UART transmitter.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Unused upper bits must be zero, so the narrower frames reduce correctly.
  function automatic logic parity_bit(input logic [8:0] d, input int mode);
    return (mode == PAR_ODD) ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with extra pointer MSB for full/empty and level decode.
module uart_sync_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         do_push, do_pop;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign level   = wptr - rptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// Configurable UART transmitter: FIFO-fed frame FSM with registered tx.
module uart_tx_fifo_cfg
  import uart_pkg::*;
#(
  parameter  int CYCLES_PER_BIT = 3125,
  parameter  int DATA_BITS      = 8,
  parameter  int PARITY_MODE    = 1,
  parameter  int STOP_BITS      = 1,
  parameter  int FIFO_DEPTH     = 4,
  localparam int LW             = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done,
  output logic [LW-1:0]        fifo_level
);

  localparam int CW = $clog2(CYCLES_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  if (CYCLES_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY_MODE < 0 || PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("uart_tx_fifo_cfg: illegal parameter set");
  end

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        bidx, bidx_n;
  logic                 sidx, sidx_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic                 par, par_n;
  logic                 tx_n, done_n;
  logic                 bit_end, load, pop;
  logic [DATA_BITS-1:0] fifo_rd;
  logic                 fifo_full, fifo_empty;

  uart_sync_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (pop),
    .wdata (in_data),
    .rdata (fifo_rd),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign in_ready = !fifo_full;
  assign busy     = (state != ST_IDLE);
  assign bit_end  = (cnt == CNT_LAST);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bidx_n  = bidx;
    sidx_n  = sidx;
    sh_n    = sh;
    par_n   = par;
    tx_n    = tx;
    done_n  = 1'b0;
    load    = 1'b0;
    pop     = 1'b0;
    if (state != ST_IDLE) cnt_n = bit_end ? '0 : cnt + CW'(1);
    case (state)
      ST_IDLE: begin
        tx_n  = 1'b1;
        cnt_n = '0;
        if (!fifo_empty) load = 1'b1;
      end
      ST_START: if (bit_end) begin
        state_n = ST_DATA;
        tx_n    = sh[0];
        sh_n    = sh >> 1;
        bidx_n  = '0;
      end
      ST_DATA: if (bit_end) begin
        if (bidx == BIT_LAST) begin
          if (PARITY_MODE != PAR_NONE) begin
            state_n = ST_PARITY;
            tx_n    = par;
          end else begin
            state_n = ST_STOP;
            tx_n    = 1'b1;
            sidx_n  = 1'b0;
          end
        end else begin
          tx_n   = sh[0];
          sh_n   = sh >> 1;
          bidx_n = bidx + BW'(1);
        end
      end
      ST_PARITY: if (bit_end) begin
        state_n = ST_STOP;
        tx_n    = 1'b1;
        sidx_n  = 1'b0;
      end
      ST_STOP: if (bit_end) begin
        if (sidx == 1'(STOP_BITS - 1)) begin
          done_n = 1'b1;
          // Chain straight into the next start bit when a word is waiting.
          if (!fifo_empty) load = 1'b1;
          else begin
            state_n = ST_IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          sidx_n = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        tx_n    = 1'b1;
        cnt_n   = '0;
      end
    endcase
    if (load) begin
      pop     = 1'b1;
      sh_n    = fifo_rd;
      par_n   = parity_bit(9'(fifo_rd), PARITY_MODE);
      tx_n    = 1'b0;
      cnt_n   = '0;
      bidx_n  = '0;
      sidx_n  = 1'b0;
      state_n = ST_START;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bidx       <= '0;
      sidx       <= 1'b0;
      sh         <= '0;
      par        <= 1'b0;
      tx         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bidx       <= bidx_n;
      sidx       <= sidx_n;
      sh         <= sh_n;
      par        <= par_n;
      tx         <= tx_n;
      frame_done <= done_n;
    end
  end

endmodule
